mvb_discard_stats: RTL and testbench

- Per-channel statistics collector for RX MAC Lite discard MVB streams.
- Generalises the fixed single-region discard tap to CHANNELS x REGIONS inputs.
- Counts valid frames and discarded frames per channel in pipelined counters. Counter width is parametrisable; the counters either saturate or wrap.
- Exposes atomic snapshot/clear through an MI slave.
- Sits beside the network module logic on the core clock. Its MVB inputs come from each channel's RX MAC Lite (discard flag + valid).

---
 rtl/mvb_discard_stats_pkg.sv | 26 ++
 rtl/mvb_discard_stats_chan.sv | 108 ++++++++++
 rtl/mvb_discard_stats.sv | 122 ++++++++++++
 tb/tb_mvb_discard_stats.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mvb_discard_stats_pkg.sv
// Shared constants and helpers for the MVB discard statistics block.
// Register offsets are relative to each channel's window.
package mvb_discard_stats_pkg;

    localparam logic [4:0] OFF_CMD    = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h04;
    localparam logic [4:0] OFF_TOT_LO = 5'h08;
    localparam logic [4:0] OFF_TOT_HI = 5'h0C;
    localparam logic [4:0] OFF_DIS_LO = 5'h10;
    localparam logic [4:0] OFF_DIS_HI = 5'h14;

    localparam int CHAN_STRIDE    = 32'h20;
    localparam int CMD_SAMPLE_BIT = 0;
    localparam int CMD_CLEAR_BIT  = 1;

    // Counts set bits of a vector of up to 64 regions
    function automatic logic [7:0] popcount_f(input logic [63:0] vec);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + {7'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mvb_discard_stats_chan.sv
// One channel: popcount stage, live counters, shadow snapshot and sticky overflow.
// Shadow/overflow next-state values are exported so a same-cycle read sees the post-write state.
module mvb_discard_stats_chan
    import mvb_discard_stats_pkg::*;
#(
    parameter int REGIONS   = 4,
    parameter int CNT_WIDTH = 48,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REGIONS-1:0]   discard,
    input  logic [REGIONS-1:0]   vld,
    input  logic                 src_rdy,
    input  logic                 sample,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] shadow_tot_nxt,
    output logic [CNT_WIDTH-1:0] shadow_dis_nxt,
    output logic                 ovf_nxt
);

    localparam int IW = $clog2(REGIONS + 1);
    // One extra bit above the wider operand so the carry out is never lost
    localparam int SW = ((CNT_WIDTH > IW) ? CNT_WIDTH : IW) + 1;

    logic [REGIONS-1:0]   tot_mask_s;
    logic [REGIONS-1:0]   dis_mask_s;
    logic [IW-1:0]        inc_tot_r;
    logic [IW-1:0]        inc_dis_r;
    logic [CNT_WIDTH-1:0] cnt_tot_r;
    logic [CNT_WIDTH-1:0] cnt_dis_r;
    logic [CNT_WIDTH-1:0] shadow_tot_r;
    logic [CNT_WIDTH-1:0] shadow_dis_r;
    logic                 ovf_r;
    logic [SW-1:0]        sum_tot_s;
    logic [SW-1:0]        sum_dis_s;
    logic [CNT_WIDTH-1:0] acc_tot_s;
    logic [CNT_WIDTH-1:0] acc_dis_s;
    logic [CNT_WIDTH-1:0] cnt_tot_nxt_s;
    logic [CNT_WIDTH-1:0] cnt_dis_nxt_s;

    function automatic logic over_f(input logic [SW-1:0] s);
        return |(s >> CNT_WIDTH);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] fold_f(input logic [SW-1:0] s);
        logic [CNT_WIDTH-1:0] r;
        if (over_f(s) && (SATURATE != 0)) begin
            r = {CNT_WIDTH{1'b1}};
        end else begin
            r = s[CNT_WIDTH-1:0];
        end
        return r;
    endfunction

    assign tot_mask_s = vld & {REGIONS{src_rdy}};
    assign dis_mask_s = tot_mask_s & discard;

    // Stage 2 next-state: accumulate, then apply clear/sample commands
    always_comb begin
        sum_tot_s      = SW'(cnt_tot_r) + SW'(inc_tot_r);
        sum_dis_s      = SW'(cnt_dis_r) + SW'(inc_dis_r);
        acc_tot_s      = fold_f(sum_tot_s);
        acc_dis_s      = fold_f(sum_dis_s);
        cnt_tot_nxt_s  = acc_tot_s;
        cnt_dis_nxt_s  = acc_dis_s;
        shadow_tot_nxt = shadow_tot_r;
        shadow_dis_nxt = shadow_dis_r;
        ovf_nxt        = ovf_r | over_f(sum_tot_s) | over_f(sum_dis_s);
        if (clear) begin
            cnt_tot_nxt_s = fold_f(SW'(inc_tot_r));
            cnt_dis_nxt_s = fold_f(SW'(inc_dis_r));
            ovf_nxt       = over_f(sum_tot_s) | over_f(sum_dis_s);
        end else begin
            cnt_tot_nxt_s = acc_tot_s;
            cnt_dis_nxt_s = acc_dis_s;
        end
        if (sample) begin
            shadow_tot_nxt = acc_tot_s;
            shadow_dis_nxt = acc_dis_s;
        end else begin
            shadow_tot_nxt = shadow_tot_r;
            shadow_dis_nxt = shadow_dis_r;
        end
    end

    // Stage 1 increments and stage 2 counter/shadow/overflow state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_tot_r    <= '0;
            inc_dis_r    <= '0;
            cnt_tot_r    <= '0;
            cnt_dis_r    <= '0;
            shadow_tot_r <= '0;
            shadow_dis_r <= '0;
            ovf_r        <= 1'b0;
        end else begin
            inc_tot_r    <= IW'(popcount_f(64'(tot_mask_s)));
            inc_dis_r    <= IW'(popcount_f(64'(dis_mask_s)));
            cnt_tot_r    <= cnt_tot_nxt_s;
            cnt_dis_r    <= cnt_dis_nxt_s;
            shadow_tot_r <= shadow_tot_nxt;
            shadow_dis_r <= shadow_dis_nxt;
            ovf_r        <= ovf_nxt;
        end
    end

endmodule

// File: rtl/mvb_discard_stats.sv
// Per-channel discard statistics for RX MAC Lite MVB streams with an MI slave.
// Top level: MI address decode and registered read mux around CHANNELS channel instances.
module mvb_discard_stats
    import mvb_discard_stats_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int REGIONS       = 4,
    parameter int CNT_WIDTH     = 48,
    parameter int SATURATE      = 1,
    parameter int MI_DATA_WIDTH = 32,
    parameter int MI_ADDR_WIDTH = 32
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic [CHANNELS*REGIONS-1:0] RX_MVB_DISCARD,
    input  logic [CHANNELS*REGIONS-1:0] RX_MVB_VLD,
    input  logic [CHANNELS-1:0]         RX_MVB_SRC_RDY,
    input  logic [MI_DATA_WIDTH-1:0]    MI_DWR,
    input  logic [MI_ADDR_WIDTH-1:0]    MI_ADDR,
    input  logic                        MI_RD,
    input  logic                        MI_WR,
    input  logic [3:0]                  MI_BE,
    output logic                        MI_ARDY,
    output logic [MI_DATA_WIDTH-1:0]    MI_DRD,
    output logic                        MI_DRDY
);

    logic [CHANNELS-1:0]      chan_hit_s;
    logic [CHANNELS-1:0]      sample_s;
    logic [CHANNELS-1:0]      clear_s;
    logic [CHANNELS-1:0]      ovf_s;
    logic [CNT_WIDTH-1:0]     shd_tot_s [CHANNELS];
    logic [CNT_WIDTH-1:0]     shd_dis_s [CHANNELS];
    logic [4:0]               off_s;
    logic                     cmd_wr_s;
    logic [63:0]              tot64_s;
    logic [63:0]              dis64_s;
    logic [MI_DATA_WIDTH-1:0] rd_data_s;
    logic [MI_DATA_WIDTH-1:0] drd_r;
    logic                     drdy_r;
    logic                     unused_s;

    assign off_s    = MI_ADDR[4:0];
    assign cmd_wr_s = MI_WR & MI_BE[0] & (off_s == OFF_CMD);
    assign MI_ARDY  = MI_RD | MI_WR;
    assign MI_DRD   = drd_r;
    assign MI_DRDY  = drdy_r;
    assign unused_s = ^{MI_BE[3:1], MI_DWR[MI_DATA_WIDTH-1:2]};

    // Channel window decode and command strobes
    always_comb begin
        chan_hit_s = '0;
        sample_s   = '0;
        clear_s    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            chan_hit_s[c] = ((MI_ADDR >> 5) == MI_ADDR_WIDTH'(c * CHAN_STRIDE / 32));
            sample_s[c]   = chan_hit_s[c] & cmd_wr_s & MI_DWR[CMD_SAMPLE_BIT];
            clear_s[c]    = chan_hit_s[c] & cmd_wr_s & MI_DWR[CMD_CLEAR_BIT];
        end
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_chan
            mvb_discard_stats_chan #(
                .REGIONS   (REGIONS),
                .CNT_WIDTH (CNT_WIDTH),
                .SATURATE  (SATURATE)
            ) u_chan (
                .clk            (CLK),
                .rst_n          (RESET_N),
                .discard        (RX_MVB_DISCARD[g*REGIONS +: REGIONS]),
                .vld            (RX_MVB_VLD[g*REGIONS +: REGIONS]),
                .src_rdy        (RX_MVB_SRC_RDY[g]),
                .sample         (sample_s[g]),
                .clear          (clear_s[g]),
                .shadow_tot_nxt (shd_tot_s[g]),
                .shadow_dis_nxt (shd_dis_s[g]),
                .ovf_nxt        (ovf_s[g])
            );
        end
    endgenerate

    // Read mux; out-of-range channels and unmapped offsets fall through to zero
    always_comb begin
        rd_data_s = '0;
        tot64_s   = 64'd0;
        dis64_s   = 64'd0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chan_hit_s[c]) begin
                tot64_s = 64'(shd_tot_s[c]);
                dis64_s = 64'(shd_dis_s[c]);
                case (off_s)
                    OFF_STATUS: rd_data_s = {31'd0, ovf_s[c]};
                    OFF_TOT_LO: rd_data_s = tot64_s[31:0];
                    OFF_TOT_HI: rd_data_s = tot64_s[63:32];
                    OFF_DIS_LO: rd_data_s = dis64_s[31:0];
                    OFF_DIS_HI: rd_data_s = dis64_s[63:32];
                    default:    rd_data_s = 32'd0;
                endcase
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    // Read response register: data one cycle after each accepted read
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            drd_r  <= '0;
            drdy_r <= 1'b0;
        end else begin
            drdy_r <= MI_RD;
            if (MI_RD) begin
                drd_r <= rd_data_s;
            end else begin
                drd_r <= drd_r;
            end
        end
    end

endmodule

// File: tb/tb_mvb_discard_stats.sv
// Directed bench: a wide saturating instance plus 4-bit saturating and wrapping instances on one bus.
module tb_mvb_discard_stats;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [15:0]      disc, vld;
    logic [3:0]       rdy;
    logic [31:0]      dwr, addr;
    logic             rd, wr;
    logic [3:0]       be;
    logic [2:0]       ardy, drdy;
    logic [2:0][31:0] drd;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int          phase;
        logic [31:0] addr;
        int          inst;
        logic [31:0] exp;
        string       name;
    } rv_t;
    rv_t tbl[$];

    always #5 clk = ~clk;

    mvb_discard_stats #(.CHANNELS(4), .REGIONS(4), .CNT_WIDTH(48), .SATURATE(1),
                        .MI_DATA_WIDTH(32), .MI_ADDR_WIDTH(32)) u_main (
        .CLK(clk), .RESET_N(rst_n), .RX_MVB_DISCARD(disc), .RX_MVB_VLD(vld),
        .RX_MVB_SRC_RDY(rdy), .MI_DWR(dwr), .MI_ADDR(addr), .MI_RD(rd), .MI_WR(wr),
        .MI_BE(be), .MI_ARDY(ardy[0]), .MI_DRD(drd[0]), .MI_DRDY(drdy[0]));

    mvb_discard_stats #(.CHANNELS(2), .REGIONS(4), .CNT_WIDTH(4), .SATURATE(1),
                        .MI_DATA_WIDTH(32), .MI_ADDR_WIDTH(32)) u_sat (
        .CLK(clk), .RESET_N(rst_n), .RX_MVB_DISCARD(disc[7:0]), .RX_MVB_VLD(vld[7:0]),
        .RX_MVB_SRC_RDY(rdy[1:0]), .MI_DWR(dwr), .MI_ADDR(addr), .MI_RD(rd), .MI_WR(wr),
        .MI_BE(be), .MI_ARDY(ardy[1]), .MI_DRD(drd[1]), .MI_DRDY(drdy[1]));

    mvb_discard_stats #(.CHANNELS(2), .REGIONS(4), .CNT_WIDTH(4), .SATURATE(0),
                        .MI_DATA_WIDTH(32), .MI_ADDR_WIDTH(32)) u_wrap (
        .CLK(clk), .RESET_N(rst_n), .RX_MVB_DISCARD(disc[7:0]), .RX_MVB_VLD(vld[7:0]),
        .RX_MVB_SRC_RDY(rdy[1:0]), .MI_DWR(dwr), .MI_ADDR(addr), .MI_RD(rd), .MI_WR(wr),
        .MI_BE(be), .MI_ARDY(ardy[2]), .MI_DRD(drd[2]), .MI_DRDY(drdy[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input int p, input logic [31:0] a, input int inst,
                       input logic [31:0] e, input string n);
        rv_t r;
        r.phase = p; r.addr = a; r.inst = inst; r.exp = e; r.name = n;
        tbl.push_back(r);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_traffic(input int ch, input logic [3:0] v, input logic [3:0] d,
                               input logic r);
        vld = 16'd0; disc = 16'd0; rdy = 4'd0;
        vld[ch*4 +: 4] = v;
        disc[ch*4 +: 4] = d;
        rdy[ch] = r;
    endtask

    task automatic traffic(input int ch, input logic [3:0] v, input logic [3:0] d,
                           input logic r, input int n);
        set_traffic(ch, v, d, r);
        repeat (n) cycle();
        set_traffic(0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic mi_write(input logic [31:0] a, input logic [31:0] data, input logic [3:0] b);
        addr = a; dwr = data; be = b; wr = 1'b1;
        cycle();
        wr = 1'b0; be = 4'd0; dwr = 32'd0;
    endtask

    task automatic mi_read(input logic [31:0] a, output logic [2:0][31:0] d);
        addr = a; rd = 1'b1;
        #1;
        chk($sformatf("ardy@%0h", a), {29'd0, ardy}, 32'd7);
        @(posedge clk);
        #1;
        rd = 1'b0;
        chk($sformatf("drdy@%0h", a), {29'd0, drdy}, 32'd7);
        d = drd;
    endtask

    task automatic run_phase(input int p);
        logic [2:0][31:0] d;
        foreach (tbl[i]) begin
            if (tbl[i].phase == p) begin
                mi_read(tbl[i].addr, d);
                chk(tbl[i].name, d[tbl[i].inst], tbl[i].exp);
            end
        end
    endtask

    task automatic sample_all();
        for (int c = 0; c < 4; c++) mi_write(32'(c * 32), 32'd1, 4'b0001);
    endtask

    initial begin
        // inst: 0 = 48-bit saturating, 1 = 4-bit saturating, 2 = 4-bit wrapping
        add(0, 32'h28, 0, 32'd0,  "rst_tot_ch1");
        add(0, 32'h30, 0, 32'd0,  "rst_dis_ch1");
        add(0, 32'h24, 0, 32'd0,  "rst_ovf_ch1");
        add(0, 32'h04, 1, 32'd0,  "rst_sat_ovf");
        add(0, 32'h08, 2, 32'd0,  "rst_wrap_tot");
        add(1, 32'h28, 0, 32'd40, "cnt_tot_ch1");
        add(1, 32'h2C, 0, 32'd0,  "cnt_tot_hi_ch1");
        add(1, 32'h30, 0, 32'd20, "cnt_dis_ch1");
        add(1, 32'h34, 0, 32'd0,  "cnt_dis_hi_ch1");
        add(1, 32'h24, 0, 32'd0,  "cnt_ovf_ch1");
        add(1, 32'h08, 0, 32'd0,  "cnt_tot_ch0");
        add(1, 32'h48, 0, 32'd0,  "cnt_tot_ch2");
        add(1, 32'h70, 0, 32'd0,  "cnt_dis_ch3");
        add(1, 32'h24, 1, 32'd1,  "cnt_sat_ovf_ch1");
        add(2, 32'h28, 0, 32'd0,  "gate_tot");
        add(2, 32'h30, 0, 32'd0,  "gate_dis");
        add(2, 32'h28, 1, 32'd0,  "gate_sat_tot");
        add(2, 32'h24, 1, 32'd0,  "clr_sat_ovf");
        add(3, 32'h08, 1, 32'd15, "sat_tot");
        add(3, 32'h04, 1, 32'd1,  "sat_ovf");
        add(3, 32'h10, 1, 32'd0,  "sat_dis");
        add(3, 32'h08, 2, 32'd0,  "wrap_tot");
        add(3, 32'h04, 2, 32'd1,  "wrap_ovf");
        add(3, 32'h08, 0, 32'd16, "wide_tot");
        add(3, 32'h04, 0, 32'd0,  "wide_ovf");
        add(4, 32'h08, 0, 32'd16, "be0_wide_tot");
        add(4, 32'h08, 1, 32'd15, "be0_sat_tot");
        add(4, 32'h04, 1, 32'd1,  "be0_sat_ovf");
        add(5, 32'h08, 0, 32'd2,  "sc_wide_tot");
        add(5, 32'h08, 1, 32'd2,  "sc_sat_tot");
        add(5, 32'h08, 2, 32'd2,  "sc_wrap_tot");
        add(5, 32'h10, 0, 32'd0,  "sc_wide_dis");
        add(6, 32'h08, 0, 32'd0,  "post_clr_tot");
        add(6, 32'h04, 0, 32'd0,  "post_clr_ovf");
        add(6, 32'h04, 1, 32'd0,  "post_clr_sat_ovf");
        add(7, 32'h28, 0, 32'd0,  "arst_tot_ch1");
        add(7, 32'h30, 0, 32'd0,  "arst_dis_ch1");
        add(7, 32'h24, 0, 32'd0,  "arst_ovf_ch1");
        add(7, 32'h08, 0, 32'd0,  "arst_tot_ch0");
        add(7, 32'h28, 1, 32'd0,  "arst_sat_tot_ch1");

        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; be = 4'd0; dwr = 32'd0; addr = 32'd0;
        set_traffic(0, 4'd0, 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        chk("rst_drdy", {29'd0, drdy}, 32'd0);
        chk("rst_drd", drd[0], 32'd0);
        run_phase(0);

        // Counting on channel 1
        traffic(1, 4'b1111, 4'b0101, 1'b1, 10);
        repeat (2) cycle();
        sample_all();
        run_phase(1);

        // Source-ready and valid gating
        mi_write(32'h20, 32'd2, 4'b0001);
        traffic(1, 4'b1111, 4'b0000, 1'b0, 5);
        traffic(1, 4'b0000, 4'b1111, 1'b1, 3);
        repeat (2) cycle();
        mi_write(32'h20, 32'd1, 4'b0001);
        run_phase(2);

        // Saturation vs wrap on channel 0
        mi_write(32'h00, 32'd2, 4'b0001);
        traffic(0, 4'b1111, 4'b0000, 1'b1, 4);
        repeat (2) cycle();
        mi_write(32'h00, 32'd1, 4'b0001);
        run_phase(3);

        // Back-to-back reads, last one beyond the 2-channel map
        addr = 32'h08; rd = 1'b1;
        #1 chk("b2b_ardy0", {29'd0, ardy}, 32'd7);
        @(posedge clk); #1;
        chk("b2b_drdy1", {29'd0, drdy}, 32'd7);
        chk("b2b_d1", drd[1], 32'd15);
        addr = 32'h0C;
        #1 chk("b2b_ardy1", {29'd0, ardy}, 32'd7);
        @(posedge clk); #1;
        chk("b2b_drdy2", {29'd0, drdy}, 32'd7);
        chk("b2b_d2", drd[1], 32'd0);
        addr = 32'h44;
        #1 chk("b2b_ardy2", {29'd0, ardy}, 32'd7);
        @(posedge clk); #1;
        rd = 1'b0;
        chk("b2b_drdy3", {29'd0, drdy}, 32'd7);
        chk("b2b_d3", drd[1], 32'd0);
        chk("b2b_d3_wide", drd[0], 32'd0);
        #1 chk("b2b_ardy_idle", {29'd0, ardy}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_drdy_end", {29'd0, drdy}, 32'd0);

        // Write with no byte enables is ignored
        mi_write(32'h00, 32'd3, 4'b0000);
        mi_write(32'h00, 32'd1, 4'b0001);
        run_phase(4);

        // SAMPLE+CLEAR two cycles after traffic
        mi_write(32'h00, 32'd2, 4'b0001);
        repeat (2) cycle();
        traffic(0, 4'b0011, 4'b0000, 1'b1, 1);
        cycle();
        mi_write(32'h00, 32'd3, 4'b0001);
        run_phase(5);
        repeat (2) cycle();
        mi_write(32'h00, 32'd1, 4'b0001);
        run_phase(6);

        // Asynchronous reset while a read response is pending
        traffic(1, 4'b1111, 4'b0011, 1'b1, 3);
        repeat (2) cycle();
        mi_write(32'h20, 32'd1, 4'b0001);
        set_traffic(1, 4'b1111, 4'b0011, 1'b1);
        addr = 32'h28; rd = 1'b1;
        cycle();
        rd = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk("arst_drdy_drop", {29'd0, drdy}, 32'd0);
        chk("arst_drd", drd[0], 32'd0);
        @(posedge clk); #1;
        set_traffic(0, 4'd0, 4'd0, 1'b0);
        chk("arst_drdy_hold", {29'd0, drdy}, 32'd0);
        rst_n = 1'b1;
        cycle();
        chk("arst_drdy_after", {29'd0, drdy}, 32'd0);
        sample_all();
        run_phase(7);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
